// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa_vr step per clock, LSB first, with a
// start/busy/done handshake and a result register that only updates on completion.

module fa_vr (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // Only WIDTH-1 partial sum bits are stored; the final bit goes straight into sum.
    logic [WIDTH-2:0] sh_s;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] s_next;

    fa_vr u_fa (fa_sum, fa_carry, sh_a[0], sh_b[0], carry);

    assign s_next   = {fa_sum, sh_s};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            sh_s  <= s_next[WIDTH-1:1];
            carry <= fa_carry;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum   <= s_next;
                c_out <= fa_carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {c_out,sum} pushed at request time,
// popped and compared when done pulses.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int checks;
    int failures;
    logic [WIDTH:0] sb_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single cycle; returns just after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic cv, input bit push);
        a     = av;
        b     = bv;
        c_in  = cv;
        start = 1'b1;
        if (push) sb_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
        step();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        c_in  = 1'($urandom);
    endtask

    task automatic wait_done(input int max_cycles, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles <= max_cycles) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                step();
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        #12;
        checks++;
        if ({busy, done, c_out, sum} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b c_out=%b sum=%h, expected all zero",
                     busy, done, c_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_latency();
        logic [WIDTH:0] exp;
        start_op(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_window[%0d]: got busy=%b done=%b, expected busy=1 done=0",
                         i, busy, done);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_latency: got done=%b busy=%b, expected done=1 busy=0", done, busy);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL zero_result: got %h, expected %h", {c_out, sum}, exp);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_one_cycle: got done=%b, expected 0", done);
        end
    endtask

    task automatic test_carry_and_hold();
        logic [WIDTH:0] exp;
        logic [WIDTH:0] held;
        int cycles;
        bit seen;
        bit hold_ok;
        start_op(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done(20, cycles, seen);
        exp = sb_q.pop_front();
        checks++;
        if (!seen || {c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL carry_out_result: got seen=%b %h, expected %h", seen, {c_out, sum}, exp);
        end
        held = {c_out, sum};
        step();
        start_op(8'h3C, 8'h0F, 1'b0, 1'b1);
        hold_ok = 1'b1;
        cycles  = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if ({c_out, sum} !== held) hold_ok = 1'b0;
            step();
            cycles++;
        end
        checks++;
        if (!hold_ok) begin
            failures++;
            $display("[TB] FAIL result_hold: got a change during SHIFT, expected %h held", held);
        end
        exp = sb_q.pop_front();
        checks++;
        if (done !== 1'b1 || {c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL second_result: got done=%b %h, expected %h", done, {c_out, sum}, exp);
        end
        step();
    endtask

    task automatic test_full_propagation();
        logic [WIDTH:0] exp;
        int cycles;
        bit seen;
        start_op(8'hA5, 8'h5A, 1'b1, 1'b1);
        wait_done(20, cycles, seen);
        exp = sb_q.pop_front();
        checks++;
        if (!seen || {c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL carry_chain: got seen=%b %h, expected %h", seen, {c_out, sum}, exp);
        end
        step();
    endtask

    task automatic test_start_ignored();
        logic [WIDTH:0] exp;
        int pulses;
        bit first;
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        step();
        step();
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        first  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first) begin
                    first = 1'b0;
                    exp = sb_q.pop_front();
                    checks++;
                    if ({c_out, sum} !== exp) begin
                        failures++;
                        $display("[TB] FAIL ignored_start_result: got %h, expected %h", {c_out, sum}, exp);
                    end
                end
            end
            step();
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL ignored_start_pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        logic [WIDTH:0] exp;
        int cycles;
        bit seen;
        start_op(8'h7F, 8'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c_out, sum} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_reset: got busy=%b done=%b c_out=%b sum=%h, expected all zero",
                     busy, done, c_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(12, cycles, seen);
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got done after %0d cycles, expected none", cycles);
        end
        start_op(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_done(20, cycles, seen);
        exp = sb_q.pop_front();
        checks++;
        if (!seen || {c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL after_abort_result: got seen=%b %h, expected %h", seen, {c_out, sum}, exp);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] exp;
        int cycles;
        bit seen;
        a     = 8'h01;
        b     = 8'h01;
        c_in  = 1'b0;
        start = 1'b1;
        sb_q.push_back(9'h002);
        step();
        a = 8'h80;
        b = 8'h80;
        sb_q.push_back(9'h100);
        wait_done(20, cycles, seen);
        exp = sb_q.pop_front();
        checks++;
        if (!seen || {c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_first: got seen=%b %h, expected %h", seen, {c_out, sum}, exp);
        end
        step();
        wait_done(20, cycles, seen);
        start = 1'b0;
        checks++;
        if (!seen || cycles != WIDTH) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got seen=%b gap=%0d, expected gap %0d", seen, cycles + 1, WIDTH + 1);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({c_out, sum} !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h, expected %h", {c_out, sum}, exp);
        end
        step();
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending busy=%b, expected 0 pending busy=0",
                     sb_q.size(), busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_latency();
        test_carry_and_hold();
        test_full_propagation();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
